uart_tx_port: RTL and testbench

- Memory-mapped UART transmitter. Acts as a responder on the SoC memory bus (valid/instr/addr/wdata/wstrb in, rdata/ready out).
- Bus writes fill a byte FIFO. A TX state machine drains the FIFO and serialises each byte as 8N1 frames on a single output line.
- Sits beside print/clint/bram behind the address decoder. Addresses arrive base-relative.

---
 rtl/uart_tx_port.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_tx_port.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_port
//  Purpose  : Memory-mapped UART transmitter. Bus writes fill a byte FIFO.
//             A TX state machine drains it as 8N1 frames on uart_tx.
//             Registers (offset addr[3:2]): 0 TXDATA, 1 STATUS, 2 DIV,
//             3 reserved.
//  Options  : define UART_TX_PARITY_EN to add an even-parity bit
//             (8E1 frames, STATUS[4]=1).
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_port #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    output logic        uart_tx,
    output logic        uart_irq
);

    localparam int              c_aw       = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]   c_full_cnt = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [c_aw:0]   c_cnt_one  = 1;
    localparam logic [c_aw-1:0] c_ptr_one  = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    // ---------------- registers ----------------
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_aw:0]   r_count;
    logic            r_ovf;
    logic [15:0]     r_div;
    logic            r_ready;
    logic [31:0]     r_rdata;

    state_t          r_state;
    logic [7:0]      r_shift;
    logic [15:0]     r_bit_div;
    logic [15:0]     r_timer;
    logic [2:0]      r_bit_idx;
    logic            r_tx;
    logic            r_irq;
`ifdef UART_TX_PARITY_EN
    logic            r_parity;
    logic            w_parity_nxt;
`endif

    // ---------------- wires ----------------
    logic [1:0]      w_sel;
    logic            w_wr;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_busy;
    logic            w_cap;
    logic [c_aw:0]   w_count_nxt;
    logic [7:0]      w_head;
    logic [15:0]     w_div_eff;
    logic            w_tick;
    logic [31:0]     w_rd_data;
    state_t          w_state_nxt;
    logic [7:0]      w_shift_nxt;
    logic [15:0]     w_bit_div_nxt;
    logic [15:0]     w_timer_nxt;
    logic [2:0]      w_bit_idx_nxt;
    logic            w_tx_nxt;
    logic            w_unused;

    // Fetch flag and unmapped address/data bits carry no meaning here.
    assign w_unused = ^{uart_instr, uart_addr[31:4], uart_addr[1:0],
                        uart_wdata[31:16], uart_wstrb[3:2]};

    assign w_sel      = uart_addr[3:2];
    assign w_wr       = uart_valid && (uart_wstrb != 4'd0);
    assign w_full     = (r_count == c_full_cnt);
    assign w_empty    = (r_count == '0);
    // A push at full is dropped even when a pop frees a slot on this edge.
    assign w_push_req = w_wr && (w_sel == 2'd0) && uart_wstrb[0];
    assign w_push     = w_push_req && !w_full;
    assign w_busy     = (r_state != S_IDLE);
    assign w_head     = r_mem[r_rptr];
    assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_tick     = (r_timer == 16'd0);
`ifdef UART_TX_PARITY_EN
    assign w_cap      = 1'b1;
`else
    assign w_cap      = 1'b0;
`endif

    assign uart_rdata = r_rdata;
    assign uart_ready = r_ready;
    assign uart_tx    = r_tx;
    assign uart_irq   = r_irq;

    // FIFO occupancy after this edge's push/pop
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + c_cnt_one;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - c_cnt_one;
    end

    // Register read mux; only read requests return data
    always_comb begin
        w_rd_data = 32'd0;
        case (w_sel)
            2'd1:    w_rd_data = {27'd0, w_cap, r_ovf, w_busy, w_empty, w_full};
            2'd2:    w_rd_data = {16'd0, r_div};
            default: w_rd_data = 32'd0;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wptr] <= uart_wdata[7:0];
    end

    // Bus response, FIFO pointers, overflow flag and divisor register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_div   <= DIV_DEFAULT;
        end else begin
            r_ready <= uart_valid;
            r_rdata <= (uart_valid && (uart_wstrb == 4'd0)) ? w_rd_data : 32'd0;
            r_count <= w_count_nxt;
            if (w_push)
                r_wptr <= r_wptr + c_ptr_one;
            if (w_pop)
                r_rptr <= r_rptr + c_ptr_one;
            if (w_push_req && w_full)
                r_ovf <= 1'b1;
            else if (w_wr && (w_sel == 2'd1) && uart_wstrb[0] && uart_wdata[3])
                r_ovf <= 1'b0;
            if (w_wr && (w_sel == 2'd2)) begin
                if (uart_wstrb[0])
                    r_div[7:0] <= uart_wdata[7:0];
                if (uart_wstrb[1])
                    r_div[15:8] <= uart_wdata[15:8];
            end
        end
    end

    // TX next-state, bit timer and shift register; uart_tx follows next state
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_shift_nxt   = r_shift;
        w_bit_div_nxt = r_bit_div;
        w_timer_nxt   = r_timer;
        w_bit_idx_nxt = r_bit_idx;
        w_tx_nxt      = 1'b1;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt  = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    // Divisor is captured per frame, so DIV writes apply next frame.
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_head;
                    w_bit_div_nxt = w_div_eff;
                    w_timer_nxt   = w_div_eff - 16'd1;
                    w_state_nxt   = S_START;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt  = ^w_head;
`endif
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_timer_nxt   = r_bit_div - 16'd1;
                end else begin
                    w_timer_nxt   = r_timer - 16'd1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_timer_nxt = r_bit_div - 16'd1;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                    w_timer_nxt = r_bit_div - 16'd1;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (w_tick)
                    w_state_nxt = S_IDLE;
                else
                    w_timer_nxt = r_timer - 16'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = w_parity_nxt;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // TX state register; reset drops any frame in flight and idles the line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= 8'd0;
            r_bit_div <= 16'd1;
            r_timer   <= 16'd0;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b1;
            r_irq     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_div <= w_bit_div_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_tx      <= w_tx_nxt;
            r_irq     <= (w_count_nxt == '0) && (w_state_nxt == S_IDLE);
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_port
//  Purpose  : Directed self-checking bench for uart_tx_port: reset state,
//             register access, frame timing, FIFO overflow, async reset
//             abort, zero divisor, reserved offset and optional parity.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_port;

`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] c_cap = 32'h10;
`else
    localparam logic [31:0] c_cap = 32'h0;
`endif

    logic        clock;
    logic        reset;
    logic        uart_valid;
    logic        uart_instr;
    logic [31:0] uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        uart_tx;
    logic        uart_irq;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rx_div  = 4;
    logic [7:0]  rx_q[$];

    uart_tx_port #(
        .FIFO_DEPTH  (8),
        .DIV_DEFAULT (16'd868)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .uart_valid (uart_valid),
        .uart_instr (uart_instr),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .uart_tx    (uart_tx),
        .uart_irq   (uart_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point for the whole bench
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        @(negedge clock);
        uart_addr  = addr;
        uart_wdata = data;
        uart_wstrb = strb;
        uart_valid = 1'b1;
        @(negedge clock);
        uart_valid = 1'b0;
        uart_wstrb = 4'd0;
        chk("wr_ready", uart_ready, 1);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp,
                            input string tag);
        @(negedge clock);
        uart_addr  = addr;
        uart_wstrb = 4'd0;
        uart_valid = 1'b1;
        @(negedge clock);
        uart_valid = 1'b0;
        chk({tag, "_ready"}, uart_ready, 1);
        chk(tag, uart_rdata, exp);
    endtask

    // Line receiver: detects a falling edge, samples the first clock of each bit
    initial begin : rx_mon
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (prev === 1'b1 && uart_tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (rx_div) @(negedge clock);
                    b[i] = uart_tx;
                end
                repeat (rx_div) @(negedge clock);
                rx_q.push_back(b);
            end
            prev = uart_tx;
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clock);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [39:0] cap40;
        logic [9:0]  cap10;
        logic [21:0] cap22;
        int          zeros;
        cap40 = '0;
        cap10 = '0;
        cap22 = '0;
        zeros = 0;

        reset      = 1'b1;
        uart_valid = 1'b0;
        uart_instr = 1'b0;
        uart_addr  = 32'd0;
        uart_wdata = 32'd0;
        uart_wstrb = 4'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // ---- reset state and register defaults ----
        chk("rst_tx", uart_tx, 1);
        chk("rst_irq", uart_irq, 1);
        chk("rst_ready", uart_ready, 0);
        chk("rst_rdata", uart_rdata, 0);
        bus_read(32'h4, 32'h2 | c_cap, "status_rst");
        @(negedge clock);
        chk("ready_one_cycle", uart_ready, 0);
        chk("rdata_idle_zero", uart_rdata, 0);
        uart_instr = 1'b1;
        bus_read(32'h8, 32'h364, "div_rst");
        uart_instr = 1'b0;

        // ---- 0x55 at DIV=4: 40-clock frame, busy mid-frame ----
        bus_write(32'h8, 32'h4, 4'b0011);
        rx_div = 4;
        rx_q.delete();
        bus_write(32'h0, 32'h55, 4'b0001);
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clock);
                    cap40[i] = uart_tx;
                end
            end
            begin
                repeat (9) @(negedge clock);
                chk("busy_irq_low", uart_irq, 0);
                bus_read(32'h4, 32'h6 | c_cap, "status_busy");
            end
        join
`ifndef UART_TX_PARITY_EN
        chk("frame_55", cap40, 40'hF0F0F0F0F0);
`endif
        @(negedge clock);
        @(negedge clock);
        chk("irq_after_stop", uart_irq, 1);
        chk("rx55_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("rx55_byte", rx_q[0], 8'h55);

        // ---- DIV=1 burst of 10 writes: 9 accepted, 10th overflows ----
        bus_write(32'h8, 32'h1, 4'b0001);
        rx_div = 1;
        rx_q.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            uart_addr  = 32'h0;
            uart_wdata = i + 1;
            uart_wstrb = 4'b0001;
            uart_valid = 1'b1;
        end
        bus_read(32'h4, 32'hD | c_cap, "status_ovf");
        bus_write(32'h4, 32'h8, 4'b0001);
        bus_read(32'h4, 32'h4 | c_cap, "status_ovf_clr");
        for (int k = 0; k < 400 && uart_irq !== 1'b1; k++) @(negedge clock);
        chk("drain_irq", uart_irq, 1);
        repeat (3) @(negedge clock);
        bus_read(32'h4, 32'h2 | c_cap, "status_drained");
        chk("burst_count", rx_q.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < rx_q.size()) chk("burst_byte", rx_q[i], i + 1);

        // ---- async reset mid data bit of 0x00 with a byte still queued ----
        bus_write(32'h8, 32'h4, 4'b0011);
        rx_div = 4;
        bus_write(32'h0, 32'h00, 4'b0001);
        bus_write(32'h0, 32'h00, 4'b0001);
        repeat (8) @(negedge clock);
        chk("pre_rst_tx_low", uart_tx, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tx", uart_tx, 1);
        chk("async_rst_irq", uart_irq, 1);
        @(negedge clock);
        reset = 1'b0;
        bus_read(32'h4, 32'h2 | c_cap, "status_after_rst");
        bus_read(32'h8, 32'h364, "div_after_rst");
        zeros = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) zeros++;
        end
        chk("no_start_after_rst", zeros, 0);
        rx_q.delete();

        // ---- DIV=0 acts as 1: 0xA5 in 10 clocks; reserved offset ----
        bus_write(32'h8, 32'h0, 4'b0011);
        rx_div = 1;
        bus_write(32'h0, 32'hA5, 4'b0001);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            cap10[i] = uart_tx;
        end
`ifndef UART_TX_PARITY_EN
        chk("frame_a5", cap10, 10'h34A);
`endif
        bus_read(32'h0, 32'h0, "txdata_rd");
        bus_read(32'hC, 32'h0, "rsvd_rd");
        bus_write(32'hC, 32'hFFFF_FFFF, 4'b1111);
        bus_read(32'h8, 32'h0, "div_zero_kept");
        repeat (4) @(negedge clock);
        chk("rxa5_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("rxa5_byte", rx_q[0], 8'hA5);

`ifdef UART_TX_PARITY_EN
        // ---- even parity: 0x07 at DIV=2 gives a 22-clock frame ----
        bus_write(32'h8, 32'h2, 4'b0011);
        rx_div = 2;
        rx_q.delete();
        bus_write(32'h0, 32'h07, 4'b0001);
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            cap22[i] = uart_tx;
        end
        chk("frame_07_par", cap22, 22'h3C00FC);
        @(negedge clock);
        bus_read(32'h4, 32'h12, "status_par_cap");
        chk("rx07_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("rx07_byte", rx_q[0], 8'h07);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
